// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default widths and the cycle-counter width helper.
package div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WORK = 1'b1
  } state_t;

  localparam int unsigned A_WIDTH_DEF = 16;
  localparam int unsigned B_WIDTH_DEF = 8;

  // Counter must reach A_WIDTH-1 with a spare bit of headroom.
  function automatic int unsigned cnt_width(input int unsigned a_width);
    return $clog2(a_width) + 1;
  endfunction

endpackage

// File: rtl/div_if.sv
// Start/busy handshake and result bus of the divider, shared with the
// multiplier harness.
interface div_if
  import div_pkg::*;
#(
  parameter int unsigned A_WIDTH = A_WIDTH_DEF,
  parameter int unsigned B_WIDTH = B_WIDTH_DEF
);

  logic [A_WIDTH-1:0] a_bi;
  logic [B_WIDTH-1:0] b_bi;
  logic               start_i;
  logic               busy_o;
  logic [A_WIDTH-1:0] q_bo;
  logic [B_WIDTH-1:0] r_bo;
  logic               dz_o;

  modport master (
    output a_bi, b_bi, start_i,
    input  busy_o, q_bo, r_bo, dz_o
  );

  modport slave (
    input  a_bi, b_bi, start_i,
    output busy_o, q_bo, r_bo, dz_o
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: compare the shifted partial remainder
// against the divisor and subtract when it fits.
module div_step #(
  parameter int unsigned B_WIDTH = 8
) (
  input  logic [B_WIDTH:0]   rem_i,
  input  logic [B_WIDTH-1:0] div_i,
  output logic [B_WIDTH-1:0] rem_o,
  output logic               qbit_o
);

  // The result is always below the divisor, so it fits in B_WIDTH bits.
  always_comb begin
    qbit_o = (rem_i >= {1'b0, div_i});
    rem_o  = qbit_o ? B_WIDTH'(rem_i - {1'b0, div_i}) : rem_i[B_WIDTH-1:0];
  end

endmodule

// File: rtl/div.sv
// Sequential restoring divider: one quotient bit per clock, start/busy
// handshake, results held until the next completion or reset.
module div
  import div_pkg::*;
#(
  parameter int unsigned A_WIDTH = A_WIDTH_DEF,
  parameter int unsigned B_WIDTH = B_WIDTH_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  div_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(A_WIDTH);

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] a_q, a_d;
  logic [B_WIDTH-1:0] d_q, d_d;
  logic [B_WIDTH-1:0] r_q, r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic [A_WIDTH-1:0] q_q, q_d;
  logic [B_WIDTH-1:0] rem_q, rem_d;
  logic               dzo_q, dzo_d;

  logic [B_WIDTH-1:0] step_rem;
  logic               step_qbit;
  logic               last_bit;

  assign last_bit = (cnt_q == CNT_W'(A_WIDTH - 1));

  // Dividend MSB shifts into the partial remainder; quotient bits refill a_q.
  div_step #(.B_WIDTH(B_WIDTH)) u_step (
    .rem_i  ({r_q, a_q[A_WIDTH-1]}),
    .div_i  (d_q),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i)       state_d = WORK;
      WORK:    if (dz_q || last_bit)  state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d    = a_q;
    d_d    = d_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
    dz_d   = dz_q;
    q_d    = q_q;
    rem_d  = rem_q;
    dzo_d  = dzo_q;
    busy_d = (state_d == WORK);
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          a_d   = bus.a_bi;
          d_d   = bus.b_bi;
          r_d   = '0;
          cnt_d = '0;
          dz_d  = (bus.b_bi == '0);
        end
      end
      WORK: begin
        if (dz_q) begin
          // Divide-by-zero: saturated quotient, low dividend bits as remainder.
          q_d   = '1;
          rem_d = a_q[B_WIDTH-1:0];
          dzo_d = 1'b1;
          dz_d  = 1'b0;
        end else begin
          a_d   = {a_q[A_WIDTH-2:0], step_qbit};
          r_d   = step_rem;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_bit) begin
            q_d   = {a_q[A_WIDTH-2:0], step_qbit};
            rem_d = step_rem;
            dzo_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q    <= '0;
      d_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      dz_q   <= 1'b0;
      busy_q <= 1'b0;
      q_q    <= '0;
      rem_q  <= '0;
      dzo_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      d_q    <= d_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      dz_q   <= dz_d;
      busy_q <= busy_d;
      q_q    <= q_d;
      rem_q  <= rem_d;
      dzo_q  <= dzo_d;
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.q_bo   = q_q;
  assign bus.r_bo   = rem_q;
  assign bus.dz_o   = dzo_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the restoring divider: vector table, scoreboard
// queue, plus reset-abort and back-to-back start sequences.
module tb_div;

  localparam int unsigned AW = 16;
  localparam int unsigned BW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  div_if #(.A_WIDTH(AW), .B_WIDTH(BW)) bus ();

  div #(.A_WIDTH(AW), .B_WIDTH(BW)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [AW-1:0] q;
    logic [BW-1:0] r;
    logic          dz;
    int            cyc;
  } vec_t;

  typedef struct {
    logic [AW-1:0] q;
    logic [BW-1:0] r;
    logic          dz;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] q, input logic [BW-1:0] r, input logic dz);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz;
    sb.push_back(e);
  endtask

  // Entered #1 after the edge that started the op; returns busy cycle count.
  task automatic wait_done(input string tag, input logic [AW-1:0] q_hold, output int cyc);
    int unstable = 0;
    cyc = 1;
    while (bus.busy_o === 1'b1 && cyc < 64) begin
      if (bus.q_bo !== q_hold) unstable++;
      @(posedge clk); #1;
      if (bus.busy_o === 1'b1) cyc++;
    end
    check({tag, "_q_stable"}, 32'(unstable), 32'd0);
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_q"},  32'(bus.q_bo), 32'(e.q));
    check({tag, "_r"},  32'(bus.r_bo), 32'(e.r));
    check({tag, "_dz"}, 32'(bus.dz_o), 32'(e.dz));
  endtask

  task automatic run_op(input vec_t v, input string tag);
    logic [AW-1:0] qh;
    int            cyc;
    @(negedge clk);
    bus.a_bi    = v.a;
    bus.b_bi    = v.b;
    bus.start_i = 1'b1;
    push_exp(v.q, v.r, v.dz);
    qh = bus.q_bo;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.a_bi    = '1;
    bus.b_bi    = '0;
    check({tag, "_busy_rise"}, 32'(bus.busy_o), 32'd1);
    wait_done(tag, qh, cyc);
    check({tag, "_cycles"}, 32'(cyc), 32'(v.cyc));
    compare_result(tag);
    if (!v.dz) begin
      check({tag, "_identity"}, 32'(bus.q_bo) * 32'(v.b) + 32'(bus.r_bo), 32'(v.a));
      check({tag, "_r_lt_b"}, 32'(bus.r_bo < v.b), 32'd1);
    end
  endtask

  function automatic vec_t mk(input int a, input int b, input int q, input int r,
                              input logic dz, input int cyc);
    vec_t v;
    v.a = AW'(a); v.b = BW'(b); v.q = AW'(q); v.r = BW'(r); v.dz = dz; v.cyc = cyc;
    return v;
  endfunction

  initial begin
    logic [AW-1:0] qh;
    int            cyc;

    for (int i = 5; i <= 9; i++) vecs.push_back(mk(i * i, i, i, 0, 1'b0, 16));
    vecs.push_back(mk(1000,  7,   142,   6,    1'b0, 16));
    vecs.push_back(mk(65535, 255, 257,   0,    1'b0, 16));
    vecs.push_back(mk(65535, 1,   65535, 0,    1'b0, 16));
    vecs.push_back(mk(3,     200, 0,     3,    1'b0, 16));
    vecs.push_back(mk(1234,  0,   65535, 'hD2, 1'b1, 1));
    vecs.push_back(mk(10,    3,   3,     1,    1'b0, 16));

    bus.a_bi    = '0;
    bus.b_bi    = '0;
    bus.start_i = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_q",    32'(bus.q_bo),   32'd0);
    check("rst_r",    32'(bus.r_bo),   32'd0);
    check("rst_dz",   32'(bus.dz_o),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) run_op(vecs[k], $sformatf("vec%0d", k));

    // Asynchronous reset in the 5th busy cycle aborts without a clock edge.
    @(negedge clk);
    bus.a_bi    = AW'(500);
    bus.b_bi    = BW'(9);
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy_o), 32'd0);
    check("abort_q",    32'(bus.q_bo),   32'd0);
    check("abort_r",    32'(bus.r_bo),   32'd0);
    check("abort_dz",   32'(bus.dz_o),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(mk(100, 3, 33, 1, 1'b0, 16), "post_abort");

    // start_i held high: operand changes mid-op are ignored, IDLE lasts one cycle.
    @(negedge clk);
    bus.a_bi    = AW'(1000);
    bus.b_bi    = BW'(7);
    bus.start_i = 1'b1;
    push_exp(AW'(142), BW'(6), 1'b0);
    qh = bus.q_bo;
    @(posedge clk); #1;
    check("b2b1_busy_rise", 32'(bus.busy_o), 32'd1);
    bus.a_bi = AW'(200);
    bus.b_bi = BW'(9);
    wait_done("b2b1", qh, cyc);
    check("b2b1_cycles", 32'(cyc), 32'd16);
    compare_result("b2b1");
    push_exp(AW'(22), BW'(2), 1'b0);
    qh = bus.q_bo;
    @(posedge clk); #1;
    check("b2b2_busy_rise", 32'(bus.busy_o), 32'd1);
    bus.a_bi = AW'(5);
    bus.b_bi = BW'(0);
    wait_done("b2b2", qh, cyc);
    bus.start_i = 1'b0;
    check("b2b2_cycles", 32'(cyc), 32'd16);
    compare_result("b2b2");
    @(posedge clk); #1;
    check("b2b_idle_after", 32'(bus.busy_o), 32'd0);
    check("b2b_hold_q", 32'(bus.q_bo), 32'd22);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
